// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-shot or auto-reload expiry and a registered terminal-count pulse.
// Optional sticky terminal-count flag (iClrTc / oTcSticky) is enabled by defining DOWN_TIMER_STICKY_TC_EN.
module down_timer #(
    parameter int LIM = 150,
    parameter int N   = $clog2(LIM)
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iEn,
    input  logic         iLoad,
    input  logic [N-1:0] iLoadVal,
    input  logic         iAutoReload,
`ifdef DOWN_TIMER_STICKY_TC_EN
    input  logic         iClrTc,
    output logic         oTcSticky,
`endif
    output logic [N-1:0] oQ,
    output logic         oTc,
    output logic         oBusy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [N-1:0] MAX_VAL = N'(LIM - 1);

    state_t       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] reload_q, reload_d;
    logic         tc_q, tc_d;
    logic [N-1:0] load_val;
    logic         terminal;
`ifdef DOWN_TIMER_STICKY_TC_EN
    logic         sticky_q, sticky_d;
`endif

    assign load_val = (iLoadVal > MAX_VAL) ? MAX_VAL : iLoadVal;
    assign terminal = (state_q == RUN) && iEn && (q_q == '0);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= MAX_VAL;
            tc_q     <= 1'b0;
`ifdef DOWN_TIMER_STICKY_TC_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
`ifdef DOWN_TIMER_STICKY_TC_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    // A load wins over a coincident terminal event and swallows its pulse.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (iLoad) begin
            state_d  = RUN;
            q_d      = load_val;
            reload_d = load_val;
        end else if (state_q == RUN && iEn) begin
            if (q_q != '0) begin
                q_d = q_q - N'(1);
            end else begin
                tc_d = 1'b1;
                if (iAutoReload) begin
                    q_d = reload_q;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

`ifdef DOWN_TIMER_STICKY_TC_EN
    always_comb begin
        sticky_d = sticky_q;
        if (terminal && !iLoad) begin
            sticky_d = 1'b1;
        end else if (iClrTc || iLoad) begin
            sticky_d = 1'b0;
        end
    end
`endif

    always_comb begin
        oQ    = q_q;
        oTc   = tc_q;
        oBusy = (state_q == RUN);
`ifdef DOWN_TIMER_STICKY_TC_EN
        oTcSticky = sticky_q;
`endif
    end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a behavioural model. Sticky-flag checks follow DOWN_TIMER_STICKY_TC_EN.
module tb_down_timer;

    localparam int LIM = 150;
    localparam int N   = $clog2(LIM);

    logic         iClk = 1'b0;
    logic         iRst;
    logic         iEn;
    logic         iLoad;
    logic [N-1:0] iLoadVal;
    logic         iAutoReload;
    logic         iClrTc;
    logic [N-1:0] oQ;
    logic         oTc;
    logic         oBusy;
`ifdef DOWN_TIMER_STICKY_TC_EN
    logic         oTcSticky;
`endif

    int errors = 0;
    int checks = 0;
    bit cmpOn  = 1'b0;

    // model state: remaining count, running flag, reload value, expected pulse and sticky flag
    int mQ = 0, mReload = LIM - 1;
    bit mRun = 0, mTc = 0, mSticky = 0;

    down_timer #(.LIM(LIM), .N(N)) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iEn         (iEn),
        .iLoad       (iLoad),
        .iLoadVal    (iLoadVal),
        .iAutoReload (iAutoReload),
`ifdef DOWN_TIMER_STICKY_TC_EN
        .iClrTc      (iClrTc),
        .oTcSticky   (oTcSticky),
`endif
        .oQ          (oQ),
        .oTc         (oTc),
        .oBusy       (oBusy)
    );

    always #5 iClk = ~iClk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // one clock cycle with the given inputs; returns after the following falling edge
    task automatic applyStimulus(input bit rst, input bit en, input bit load, input int val,
                                 input bit ar, input bit clr);
        iRst        = rst;
        iEn         = en;
        iLoad       = load;
        iLoadVal    = N'(val);
        iAutoReload = ar;
        iClrTc      = clr;
        @(posedge iClk);
        @(negedge iClk);
    endtask

    // Reference behaviour: a loaded timer counts enabled ticks down from min(val, LIM-1);
    // the enabled tick that finds it at zero is the expiry, which pulses and then reloads or stops.
    always @(posedge iClk) begin
        if (iRst) begin
            mQ = 0; mRun = 0; mTc = 0; mReload = LIM - 1; mSticky = 0;
        end else begin
            bit expire;
            expire = mRun && iEn && (mQ == 0) && !iLoad;
            mTc = expire;
            if (iLoad) begin
                mQ = (int'(iLoadVal) > LIM - 1) ? LIM - 1 : int'(iLoadVal);
                mReload = mQ;
                mRun = 1;
            end else if (mRun && iEn) begin
                if (mQ > 0) mQ = mQ - 1;
                else if (iAutoReload) mQ = mReload;
                else mRun = 0;
            end
            if (expire) mSticky = 1;
            else if (iClrTc || iLoad) mSticky = 0;
        end
    end

    always @(negedge iClk) begin
        if (cmpOn) begin
            checkOutput("model_q", int'(oQ), mQ);
            checkOutput("model_tc", int'(oTc), int'(mTc));
            checkOutput("model_busy", int'(oBusy), int'(mRun));
`ifdef DOWN_TIMER_STICKY_TC_EN
            checkOutput("model_sticky", int'(oTcSticky), int'(mSticky));
`endif
        end
    end

    initial begin
        int pulses, busyLow, ticks, seen;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 7, 1, 0);
        cmpOn = 1'b1;
        checkOutput("reset_q", int'(oQ), 0);
        checkOutput("reset_tc", int'(oTc), 0);
        checkOutput("reset_busy", int'(oBusy), 0);

        // one-shot load of 3
        applyStimulus(0, 1, 1, 3, 0, 0);
        checkOutput("os_load_q", int'(oQ), 3);
        checkOutput("os_load_busy", int'(oBusy), 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("os_q2", int'(oQ), 2);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("os_q1", int'(oQ), 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("os_q0", int'(oQ), 0);
        checkOutput("os_no_tc_yet", int'(oTc), 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("os_tc", int'(oTc), 1);
        checkOutput("os_busy_fall", int'(oBusy), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("os_idle_q", int'(oQ), 0);
        checkOutput("os_idle_tc", int'(oTc), 0);

        // auto-reload of 2 over 12 enabled cycles
        applyStimulus(0, 1, 1, 2, 1, 0);
        checkOutput("ar_load_q", int'(oQ), 2);
        pulses = 0; busyLow = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 0, 0, 1, 0);
            if (oTc) pulses++;
            if (!oBusy) busyLow++;
        end
        checkOutput("ar_pulses", pulses, 4);
        checkOutput("ar_busy_low", busyLow, 0);
        checkOutput("ar_end_q", int'(oQ), 2);

        // oversized load clamps to LIM-1 and expires after LIM ticks
        applyStimulus(0, 0, 1, 200, 0, 0);
        checkOutput("clamp_q", int'(oQ), LIM - 1);
        ticks = 0; seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            ticks++;
            if (oTc) seen = ticks;
        end
        checkOutput("clamp_ticks", seen, LIM);

        // gated enable: only enabled cycles count
        applyStimulus(0, 0, 1, 5, 0, 0);
        ticks = 0; seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            bit en;
            en = (i % 3 == 0);
            applyStimulus(0, en, 0, 0, 0, 0);
            if (en) ticks++;
            if (i == 0) checkOutput("gate_first_q", int'(oQ), 4);
            if (i == 1) checkOutput("gate_hold_q", int'(oQ), 4);
            if (oTc) seen = ticks;
        end
        checkOutput("gate_ticks", seen, 6);

        // load coinciding with expiry suppresses the pulse; reset mid-count
        applyStimulus(0, 1, 1, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("coll_q0", int'(oQ), 0);
        applyStimulus(0, 1, 1, 4, 1, 0);
        checkOutput("coll_tc", int'(oTc), 0);
        checkOutput("coll_q", int'(oQ), 4);
        applyStimulus(0, 1, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("pre_rst_q", int'(oQ), 2);
        applyStimulus(1, 1, 0, 0, 1, 0);
        checkOutput("rst_q", int'(oQ), 0);
        checkOutput("rst_busy", int'(oBusy), 0);
        checkOutput("rst_tc", int'(oTc), 0);

`ifdef DOWN_TIMER_STICKY_TC_EN
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("sticky_tc", int'(oTc), 1);
        checkOutput("sticky_set", int'(oTcSticky), 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("sticky_hold", int'(oTcSticky), 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("sticky_clr", int'(oTcSticky), 0);
        applyStimulus(0, 1, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 1);
        checkOutput("sticky_set_wins_tc", int'(oTc), 1);
        checkOutput("sticky_set_wins", int'(oTcSticky), 1);
`endif

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7) == 0);
        end

        cmpOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counter/timer, the counting-down counterpart of the team's free-running up-counter.
- Used for VGA blanking/porch intervals, sprite move delays and frame-rate dividers, where a duration is programmed and expiry must be signalled.
- Counts enabled ticks from a loaded value down to zero and issues a one-cycle terminal-count pulse.
- Then either stops (one-shot) or reloads and continues (auto-reload).

Parameters:
- LIM, 150, maximum count span; loadable values are 0..LIM-1.
- N, $clog2(LIM), counter width; LIM >= 2 required.

Ports:
- iClk  input  1  clock; all state changes on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iEn  input  1  count-enable tick, e.g. pixel-clock enable or frame strobe.
- iLoad  input  1  load strobe; loads iLoadVal and starts the timer.
- iLoadVal  input  N  value to load; clamped to LIM-1.
- iAutoReload  input  1  1 = reload after expiry; 0 = one-shot. Sampled at the terminal event.
- oQ  output  N  current count.
- oTc  output  1  terminal-count pulse, registered, one cycle wide.
- oBusy  output  1  high while in state RUN.

Behaviour:
- Interface: one clock iClk; iRst is synchronous and active-high.
- Reset:
  - oQ=0, oTc=0, oBusy=0, state IDLE.
  - Internal reload register rReload = LIM-1.
  - iRst overrides every other input, including mid-count.
- States are IDLE and RUN; oBusy = (state==RUN), registered.
- Load, applied in any state with highest priority after reset:
  - v = min(iLoadVal, LIM-1).
  - Next cycle: oQ=v, rReload=v, state RUN, oTc=0.
  - Load is independent of iEn.
  - A load that coincides with a terminal event suppresses that event's oTc.
- IDLE: iEn is ignored and oQ holds its value.
- RUN, iEn=1, oQ>0: oQ <= oQ-1.
- RUN, iEn=1, oQ==0 (terminal event):
  - oTc=1 in the next cycle only.
  - If iAutoReload=1: oQ <= rReload and the state stays RUN.
  - Else: the state goes to IDLE and oQ stays 0.
- RUN, iEn=0: everything holds and oTc=0.
- Period: for loaded value v, oTc fires after exactly v+1 enabled ticks. This matches the up-counter period when v=LIM-1.
- Load value 0: the first enabled tick after the load is the terminal event.
- Auto-reload with rReload=0 gives oTc on every enabled tick.
- oTc never stays high for two consecutive cycles unless two consecutive terminal events occur, which is possible only with rReload=0 and iEn held high.
- Arithmetic: unsigned, N bits. oQ never goes below 0 and never exceeds LIM-1; no wrap-around through 2^N-1.
- Latency: every output is registered, so an input affects the outputs on the next rising edge.

Optional Feature:
Macro DOWN_TIMER_STICKY_TC_EN.
- Defined:
  - Adds input iClrTc (1 bit) and output oTcSticky (1 bit).
  - oTcSticky is set on every terminal event that produces oTc.
  - It is cleared by iClrTc or by iLoad; set wins if it coincides with iClrTc.
  - Reset value 0.
- Not defined: neither port exists and behaviour is otherwise identical.

Test Plan:
1. Reset, then load iLoadVal=3 with iAutoReload=0 and iEn=1 continuously.
   - oQ sequence 3,2,1,0, then oTc=1 for one cycle.
   - oBusy falls in the same cycle as oTc; oQ then holds 0 and further iEn is ignored.
2. Load 2 with iAutoReload=1 and iEn=1 for 12 cycles.
   - oQ cycles 2,1,0,2,1,0,...
   - oTc pulses every 3rd cycle, 4 pulses total; oBusy stays 1.
3. Load iLoadVal=200 with LIM=150.
   - oQ=149, and the terminal event comes after 150 enabled ticks.
4. Load 5, then toggle iEn 1,0,0,1,...
   - oQ decrements only on iEn=1 cycles; oTc arrives after the 6th enabled tick.
5. Load 1 with auto-reload, then assert iLoad with value 4 in the same cycle as the terminal event.
   - No oTc; oQ=4 next cycle.
   - Then assert iRst mid-count at oQ=2: oQ=0, oBusy=0, oTc=0 next cycle, and the reload value returns to LIM-1.
6. With DOWN_TIMER_STICKY_TC_EN defined, load 0 with iEn=1 and iAutoReload=0.
   - oTc and oTcSticky rise together; oTcSticky stays 1 until iClrTc.
   - iClrTc coincident with a new terminal event leaves oTcSticky=1.
